// File: rtl/cache_line_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_line_refill_ctrl
//  Purpose  : Sequences a full 8-word cache-line replacement after a miss.
//             A dirty victim is first written back as 8 beats (words 0..7).
//             The new line is then fetched as 8 beats over a req/ack
//             handshake. Each fetched word is written into the line through
//             a one-hot word enable, and the tag is updated last.
//  Option   : CRITICAL_WORD_FIRST_EN
//               defined   - fill starts at the missed word and wraps 7->0;
//                           stall_release pulses when that word is written.
//               undefined - fill starts at word 0; stall_release pulses
//                           together with done.
//  Ports    : clk, rst_n (sync, active low)
//             miss_req/miss_addr/victim_dirty/victim_addr : miss request
//             busy, done, stall_release                   : status to cache
//             mem_req/mem_we/mem_addr/mem_wdata/
//             mem_ack/mem_rdata                           : memory beats
//             line_rd_word/line_rdata                     : victim word read
//             line_we/word_enable/line_wdata/tag_we       : line/tag update
//  Revision : 1.0  initial release
// ============================================================================
module cache_line_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    output logic              busy,
    output logic              done,
    output logic              stall_release,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        line_rd_word,
    input  logic [DATA_W-1:0] line_rdata,
    output logic              line_we,
    output logic [7:0]        word_enable,
    output logic [DATA_W-1:0] line_wdata,
    output logic              tag_we
);

    localparam logic [2:0] c_LAST_BEAT = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WB      = 3'd1,
        S_WB_GAP  = 3'd2,
        S_FILL    = 3'd3,
        S_FILL_WR = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_k;
    logic [2:0]        w_k_next;
    logic [ADDR_W-6:0] r_miss_line;
    logic [ADDR_W-6:0] r_victim_line;
    logic [DATA_W-1:0] r_fill_data;
    logic [2:0]        r_fill_w;
    logic              w_latch;
    logic              w_capture;
    logic [2:0]        w_start;
    logic [2:0]        w_word;
    logic              w_unused;

`ifdef CRITICAL_WORD_FIRST_EN
    logic [2:0]        r_crit_word;
    assign w_start = r_crit_word;
`else
    assign w_start = 3'd0;
`endif

    // Fill word index wraps naturally in 3 bits.
    assign w_word = w_start + r_k;

    // Byte offset bits of the request addresses are only partly consumed.
    assign w_unused = &{1'b0, miss_addr[4:0], victim_addr[4:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_k           <= 3'd0;
            r_miss_line   <= '0;
            r_victim_line <= '0;
            r_fill_data   <= '0;
            r_fill_w      <= 3'd0;
`ifdef CRITICAL_WORD_FIRST_EN
            r_crit_word   <= 3'd0;
`endif
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
            if (w_latch) begin
                r_miss_line   <= miss_addr[ADDR_W-1:5];
                r_victim_line <= victim_addr[ADDR_W-1:5];
`ifdef CRITICAL_WORD_FIRST_EN
                r_crit_word   <= miss_addr[4:2];
`endif
            end
            if (w_capture) begin
                r_fill_data <= mem_rdata;
                r_fill_w    <= w_word;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_k_next      = r_k;
        w_latch       = 1'b0;
        w_capture     = 1'b0;
        busy          = (r_state != S_IDLE);
        done          = 1'b0;
        stall_release = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        line_rd_word  = 3'd0;
        line_we       = 1'b0;
        word_enable   = 8'd0;
        line_wdata    = '0;
        tag_we        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (miss_req) begin
                    w_latch      = 1'b1;
                    w_k_next     = 3'd0;
                    w_state_next = victim_dirty ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                // Victim words always go out in order 0..7.
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                line_rd_word = r_k;
                mem_addr     = {r_victim_line, r_k, 2'b00};
                mem_wdata    = line_rdata;
                if (mem_ack) begin
                    w_state_next = S_WB_GAP;
                end
            end
            S_WB_GAP: begin
                if (r_k == c_LAST_BEAT) begin
                    w_k_next     = 3'd0;
                    w_state_next = S_FILL;
                end else begin
                    w_k_next     = r_k + 3'd1;
                    w_state_next = S_WB;
                end
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_miss_line, w_word, 2'b00};
                if (mem_ack) begin
                    w_capture    = 1'b1;
                    w_state_next = S_FILL_WR;
                end
            end
            S_FILL_WR: begin
                line_we     = 1'b1;
                word_enable = 8'd1 << r_fill_w;
                line_wdata  = r_fill_data;
`ifdef CRITICAL_WORD_FIRST_EN
                stall_release = (r_fill_w == r_crit_word);
`endif
                if (r_k == c_LAST_BEAT) begin
                    w_state_next = S_DONE;
                end else begin
                    w_k_next     = r_k + 3'd1;
                    w_state_next = S_FILL;
                end
            end
            S_DONE: begin
                tag_we = 1'b1;
                done   = 1'b1;
`ifndef CRITICAL_WORD_FIRST_EN
                stall_release = 1'b1;
`endif
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_line_refill_ctrl
//  Purpose  : Self-checking bench for cache_line_refill_ctrl. A memory
//             responder with random ack delays drives the DUT, and each
//             transaction is compared with the beat list, fill order and
//             line contents predicted from the miss parameters.
//  Option   : CRITICAL_WORD_FIRST_EN selects the expected fill order.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_line_refill_ctrl;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit c_CWF = 1'b1;
`else
    localparam bit c_CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        victim_dirty;
    logic [31:0] victim_addr;
    logic        busy;
    logic        done;
    logic        stall_release;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [2:0]  line_rd_word;
    logic [31:0] line_rdata;
    logic        line_we;
    logic [7:0]  word_enable;
    logic [31:0] line_wdata;
    logic        tag_we;

    logic [31:0]  vline [8];
    logic [113:0] outs;
    int           n_pass;
    int           n_total;

    assign line_rdata = vline[line_rd_word];
    assign outs = {busy, done, stall_release, mem_req, mem_we, mem_addr,
                   mem_wdata, line_rd_word, line_we, word_enable,
                   line_wdata, tag_we};

    always #5 clk = ~clk;

    cache_line_refill_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .victim_dirty (victim_dirty),
        .victim_addr  (victim_addr),
        .busy         (busy),
        .done         (done),
        .stall_release(stall_release),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .line_rd_word (line_rd_word),
        .line_rdata   (line_rdata),
        .line_we      (line_we),
        .word_enable  (word_enable),
        .line_wdata   (line_wdata),
        .tag_we       (tag_we)
    );

    // Runs one replacement. Cycle 0 is the cycle in which miss_req is sampled
    // in IDLE. With pre=1 the caller has already raised miss_req and we are at
    // the falling edge of cycle 0. Returns at the falling edge of the done
    // cycle, or at the first sight of beat abort_bi (without acking it).
    task automatic run_miss(input logic [31:0] maddr, input logic [31:0] vaddr,
                            input bit dirty, input int maxdly, input bit toggle,
                            input bit pre, input int abort_bi,
                            output int done_cyc, output logic [7:0] first_we);
        logic [31:0] exp_addr[$];
        bit          exp_we[$];
        int          exp_w[$];
        logic [31:0] exp_d[$];
        int          start, bi, nbeats, cyc, dly, n_we, fi, w;
        bit          waiting, prev_acked, exp_sr;
        logic [31:0] h_addr, h_wdata, d;
        logic        h_we;
        logic [7:0]  covered;

        done_cyc = -1;
        first_we = 8'd0;
        for (int i = 0; i < 8; i++) vline[i] = $urandom;
        start = c_CWF ? int'(maddr[4:2]) : 0;
        if (dirty) begin
            for (int i = 0; i < 8; i++) begin
                exp_addr.push_back((vaddr & ~32'h1F) + 32'(4 * i));
                exp_we.push_back(1'b1);
            end
        end
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back((maddr & ~32'h1F) + 32'(4 * ((start + i) % 8)));
            exp_we.push_back(1'b0);
        end
        nbeats = exp_addr.size();

        if (!pre) begin
            @(negedge clk);
            miss_req     = 1'b1;
            miss_addr    = maddr;
            victim_addr  = vaddr;
            victim_dirty = dirty;
        end
        cyc = 0; bi = 0; dly = 0; n_we = 0; covered = 8'd0;
        waiting = 1'b0; prev_acked = 1'b0;
        h_addr = '0; h_wdata = '0; h_we = 1'b0;

        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) miss_req = 1'b0;
            if (cyc > 2000) begin
                n_total++;
                $display("FAIL timeout: no done after %0d cycles (beats seen %0d, required %0d)",
                         cyc, bi, nbeats);
                mem_ack = 1'b0;
                return;
            end

            n_total++;
            if (busy !== 1'b1) $display("FAIL busy cyc %0d: got %b required 1", cyc, busy);
            else n_pass++;

            if (done === 1'b1 || tag_we === 1'b1) begin
                done_cyc = cyc;
                n_total++;
                if ({done, tag_we, stall_release} !== {2'b11, !c_CWF})
                    $display("FAIL done_pulse: got done/tag_we/stall %b%b%b required 11%b",
                             done, tag_we, stall_release, !c_CWF);
                else n_pass++;
                n_total++;
                if (n_we != 8 || covered !== 8'hFF || bi != nbeats)
                    $display("FAIL completion: got we=%0d cover=%h beats=%0d required 8/ff/%0d",
                             n_we, covered, bi, nbeats);
                else n_pass++;
                mem_ack = 1'b0;
                break;
            end

            if (prev_acked) begin
                n_total++;
                if (mem_req !== 1'b0) $display("FAIL req_gap cyc %0d: got mem_req %b required 0", cyc, mem_req);
                else n_pass++;
            end

            if (line_we === 1'b1 || stall_release === 1'b1) begin
                exp_sr = (line_we === 1'b1) && c_CWF && (n_we == 0);
                n_total++;
                if (stall_release !== exp_sr)
                    $display("FAIL stall_release cyc %0d: got %b required %b", cyc, stall_release, exp_sr);
                else n_pass++;
            end

            if (line_we === 1'b1) begin
                n_total++;
                if (exp_w.size() == 0) begin
                    $display("FAIL line_we cyc %0d: got unexpected write en=%h required none", cyc, word_enable);
                end else begin
                    w = exp_w.pop_front();
                    d = exp_d.pop_front();
                    if (word_enable !== 8'(1 << w) || line_wdata !== d)
                        $display("FAIL fill_write cyc %0d: got en=%h data=%h required en=%h data=%h",
                                 cyc, word_enable, line_wdata, 8'(1 << w), d);
                    else n_pass++;
                end
                if (n_we == 0) first_we = word_enable;
                covered |= word_enable;
                n_we++;
            end

            if (waiting) begin
                n_total++;
                if (mem_req !== 1'b1 || mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata)
                    $display("FAIL hold cyc %0d: got req=%b addr=%h we=%b wd=%h required 1/%h/%b/%h",
                             cyc, mem_req, mem_addr, mem_we, mem_wdata, h_addr, h_we, h_wdata);
                else n_pass++;
            end else if (mem_req === 1'b1) begin
                if (bi == abort_bi) begin
                    mem_ack = 1'b0;
                    return;
                end
                n_total++;
                if (bi >= nbeats) begin
                    $display("FAIL extra_beat cyc %0d: got addr %h required no beat", cyc, mem_addr);
                end else if (mem_addr !== exp_addr[bi] || mem_we !== exp_we[bi] ||
                             (exp_we[bi] && (mem_wdata !== vline[bi] || line_rd_word !== 3'(bi)))) begin
                    $display("FAIL beat %0d: got addr=%h we=%b wd=%h rd=%0d required %h/%b",
                             bi, mem_addr, mem_we, mem_wdata, line_rd_word, exp_addr[bi], exp_we[bi]);
                end else n_pass++;
                h_addr  = mem_addr;
                h_we    = mem_we;
                h_wdata = mem_wdata;
                waiting = 1'b1;
                dly = (maxdly > 0) ? int'($urandom_range(maxdly, 0)) : 0;
            end

            prev_acked = 1'b0;
            if (waiting) begin
                if (dly == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = $urandom;
                    fi = bi - (dirty ? 8 : 0);
                    if (fi >= 0) begin
                        exp_w.push_back((start + fi) % 8);
                        exp_d.push_back(mem_rdata);
                    end
                    bi++;
                    waiting    = 1'b0;
                    prev_acked = 1'b1;
                end else begin
                    dly--;
                    mem_ack = 1'b0;
                end
            end else begin
                // Spurious acks while no request is pending must be ignored.
                mem_ack = (maxdly > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
            end

            if (toggle) begin
                miss_req     = 1'($urandom_range(1, 0));
                miss_addr    = $urandom;
                victim_addr  = $urandom;
                victim_dirty = 1'($urandom_range(1, 0));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; miss_req = 1'b1; miss_addr = 32'h1234; mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h required 0", outs);
        else n_pass++;
        rst_n = 1'b1; miss_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        n_total++;
        if (outs !== '0) $display("FAIL idle_outputs: got %h required 0", outs);
        else n_pass++;
    endtask

    task automatic test_clean_miss();
        int dc; logic [7:0] fw;
        run_miss(32'h0000_1234, 32'h0, 1'b0, 0, 1'b0, 1'b0, -1, dc, fw);
        miss_req = 1'b0; mem_ack = 1'b0;
        n_total++;
        if (dc != 17) $display("FAIL clean_latency: got %0d required 17", dc);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL clean_busy_clear: got busy=%b done=%b required 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_dirty_miss();
        int dc; logic [7:0] fw;
        run_miss(32'h0000_8ABC, 32'h0000_4000, 1'b1, 0, 1'b0, 1'b0, -1, dc, fw);
        miss_req = 1'b0; mem_ack = 1'b0;
        n_total++;
        if (dc != 33) $display("FAIL dirty_latency: got %0d required 33", dc);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL dirty_busy_clear: got %b required 0", busy);
        else n_pass++;
    endtask

    task automatic test_critical_word();
        int dc; logic [7:0] fw; logic [7:0] exp_fw;
        exp_fw = c_CWF ? 8'h40 : 8'h01;
        run_miss(32'h0000_1238, 32'h0, 1'b0, 0, 1'b0, 1'b0, -1, dc, fw);
        miss_req = 1'b0; mem_ack = 1'b0;
        n_total++;
        if (fw !== exp_fw || dc != 17)
            $display("FAIL critical_word: got first_en=%h done=%0d required %h 17", fw, dc, exp_fw);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random_delays();
        int dc; logic [7:0] fw; bit dirty;
        for (int it = 0; it < 6; it++) begin
            dirty = 1'($urandom_range(1, 0));
            run_miss($urandom, $urandom, dirty, 5, 1'(it % 2), 1'b0, -1, dc, fw);
            miss_req = 1'b0; mem_ack = 1'b0;
            n_total++;
            if (dc < (dirty ? 33 : 17))
                $display("FAIL rand_latency %0d: got %0d required >= %0d", it, dc, dirty ? 33 : 17);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (busy !== 1'b0) $display("FAIL rand_busy_clear %0d: got %b required 0", it, busy);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_fill();
        int dc; logic [7:0] fw;
        run_miss(32'h0000_1234, 32'h0, 1'b0, 0, 1'b0, 1'b0, 3, dc, fw);
        rst_n = 1'b0;
        @(negedge clk);
        n_total++;
        if (outs !== '0) $display("FAIL abort_outputs: got %h required 0", outs);
        else n_pass++;
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_total++;
            if (line_we !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0)
                $display("FAIL late_ack %0d: got we=%b busy=%b req=%b required 0 0 0", i, line_we, busy, mem_req);
            else n_pass++;
        end
        mem_ack = 1'b0;
        run_miss(32'h0000_5678, 32'h0, 1'b0, 0, 1'b0, 1'b0, -1, dc, fw);
        miss_req = 1'b0; mem_ack = 1'b0;
        n_total++;
        if (dc != 17) $display("FAIL restart_latency: got %0d required 17", dc);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_miss_while_busy();
        int dc; logic [7:0] fw;
        run_miss(32'h0000_9A40, 32'h0000_2000, 1'b1, 2, 1'b1, 1'b0, -1, dc, fw);
        // Hold a new miss high through DONE; it must wait for the IDLE cycle.
        miss_req = 1'b1; miss_addr = 32'h0000_1234; victim_addr = 32'h0; victim_dirty = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL held_miss_idle: got busy %b required 0", busy);
        else n_pass++;
        run_miss(32'h0000_1234, 32'h0, 1'b0, 0, 1'b0, 1'b1, -1, dc, fw);
        miss_req = 1'b0; mem_ack = 1'b0;
        n_total++;
        if (dc != 17) $display("FAIL held_miss_latency: got %0d required 17", dc);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
        victim_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 8; i++) vline[i] = '0;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_critical_word();
        test_random_delays();
        test_reset_mid_fill();
        test_miss_while_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_line_refill_ctrl.md
Name: cache_line_refill_ctrl

Overview:
- Sequences a full 8-word cache-line replacement on a miss in the MIPS data/instruction cache.
- On a dirty victim, first writes back the 8 victim words. Then fetches 8 words from memory over a req/ack handshake.
- Writes each fetched word into the line through a one-hot 8-bit word enable, then updates the tag.
- Sits between the cache hit/miss logic and the memory bus interface.

Parameters:
ADDR_W, 32, byte-address width; line = 8 words x 4 bytes, offset bits [4:0]
DATA_W, 32, word width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
miss_req  in  1  miss request, sampled only in IDLE
miss_addr  in  ADDR_W  byte address of missing access
victim_dirty  in  1  victim line dirty flag, sampled with miss_req
victim_addr  in  ADDR_W  victim line base address, sampled with miss_req
busy  out  1  high from cycle after acceptance until DONE exits
done  out  1  one-cycle pulse, replacement complete
stall_release  out  1  one-cycle pulse, missed word now in line
mem_req  out  1  memory beat request
mem_we  out  1  1 = write-back beat, 0 = fill beat
mem_addr  out  ADDR_W  word-aligned beat address
mem_wdata  out  DATA_W  write-back data (= line_rdata)
mem_ack  in  1  beat accepted/complete
mem_rdata  in  DATA_W  fill data, valid when mem_ack && !mem_we
line_rd_word  out  3  victim word index being read (combinational line_rdata path)
line_rdata  in  DATA_W  victim word data
line_we  out  1  line write strobe
word_enable  out  8  one-hot word select for line write, 0 when line_we=0
line_wdata  out  DATA_W  word written into line
tag_we  out  1  tag/valid/clear-dirty write strobe

Behaviour:
- States: IDLE, WB, WB_GAP, FILL, FILL_WR, DONE. 3-bit beat counter k.
- Reset (rst_n=0 at a clock edge): state=IDLE, k=0. All outputs 0, including mem_addr/mem_wdata/line_wdata.
- Reset mid-operation aborts immediately. A mem_ack arriving after reset is ignored. No partial tag write.
- IDLE: miss_req=1 latches miss_addr, victim_addr and victim_dirty; k=0.
  - Next state is WB if dirty, else FILL.
  - miss_req is ignored in all states other than IDLE.
- WB:
  - mem_req=1, mem_we=1, line_rd_word=k.
  - mem_addr={victim_addr[ADDR_W-1:5],k,2'b00}; mem_wdata=line_rdata.
  - Outputs are held stable until mem_ack=1 at an edge. On that edge go to WB_GAP.
- WB_GAP:
  - mem_req=0.
  - If k==7: k=0, go to FILL. Else k=k+1, go to WB.
- FILL:
  - mem_req=1, mem_we=0.
  - Word index w=(start+k) mod 8 (3-bit wrap). mem_addr={miss_addr[ADDR_W-1:5],w,2'b00}.
  - On mem_ack: capture mem_rdata and w into registers, go to FILL_WR.
- FILL_WR:
  - mem_req=0. line_we=1, word_enable=1<<w_reg, line_wdata=captured data.
  - stall_release=1 if w_reg==miss_addr[4:2] and the feature macro is defined.
  - If k==7 go to DONE, else k=k+1 and go to FILL.
- DONE:
  - tag_we=1, done=1, stall_release=1 when the feature macro is not defined.
  - Next state IDLE. busy=0 in that IDLE cycle.
- Handshake:
  - mem_req never asserted back-to-back; min 2 cycles per beat.
  - mem_ack while mem_req=0 is ignored.
  - Wait states are unbounded.
- Latency with zero-wait ack, where cycle 0 = miss_req sampled in IDLE:
  - Clean miss: done in cycle 17.
  - Dirty miss: done in cycle 33.
- word_enable is always one-hot or zero, never multi-hot.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined:
  - Fill start = miss_addr[4:2]; order wraps 7 -> 0.
  - stall_release pulses in the FILL_WR cycle of beat 0.
  - Write-back order is unchanged (0..7).
- Undefined:
  - Fill start = 0.
  - stall_release pulses together with done.

Test Plan:
- Clean miss, miss_addr=0x0000_1234, ack same cycle as req:
  - Fill mem_addr sequence 0x1220,0x1224,...,0x123C, no mem_we.
  - word_enable 0x01,0x02,...,0x80.
  - tag_we and done in cycle 17; busy cleared cycle 18.
- Dirty miss, victim_addr=0x0000_4000:
  - 8 write beats 0x4000..0x401C, line_rd_word 0..7, mem_wdata matches line_rdata.
  - Then 8 fill beats; done in cycle 33.
- Random 0-5 cycle ack delays:
  - mem_req/mem_addr/mem_wdata stable until ack.
  - Exactly 8 line_we pulses, each one-hot, all 8 words covered once.
- CRITICAL_WORD_FIRST_EN defined, miss_addr=0x0000_1238 (word 6):
  - Fill order words 6,7,0,1,...,5.
  - stall_release in the first FILL_WR cycle (word_enable=0x40).
  - done still after 8 beats.
- rst_n=0 during FILL beat 3:
  - Next cycle all outputs 0, state IDLE.
  - A late mem_ack causes no line_we.
  - A new miss restarts at beat 0.
- miss_req toggled while busy:
  - Ignored, no relatch of miss_addr.
  - A miss_req held high through DONE is accepted in the following IDLE cycle.
